dmem_port_ctrl: RTL and testbench

Controller for the single-port data memory in the MEM stage. It shares the memory between two requesters: the pipeline (MEM-stage load/store address) and the secondary address port (fill/debug requester). It drives the address-mux select, sequences hit/miss accesses with a fixed miss penalty, and stalls the pipeline while the memory is unavailable to it. Pipeline has priority, with a starvation limit so the secondary port always makes progress.

---
 rtl/dmem_ctrl_pkg.sv | 15 +
 rtl/dmem_port_arbiter.sv | 46 ++++
 rtl/dmem_port_ctrl.sv | 114 +++++++++++
 tb/tb_dmem_port_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the MEM-stage data memory port controller.
package dmem_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } state_e;

    // Owner values double as the address-mux select.
    typedef enum logic {
        OWN_P = 1'b0,
        OWN_F = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Pipeline-priority grant logic with a starvation counter that forces the
// secondary port through after STARVE_LIMIT consecutive pipeline completions.
module dmem_port_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic arb_en_i,
    input  logic p_req_i,
    input  logic f_req_i,
    input  logic p_done_i,
    input  logic f_done_i,
    output logic grant_p_o,
    output logic grant_f_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SCNT_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] scnt_q, scnt_d;
    logic          starved;

    always_comb begin
        starved   = (scnt_q == SCNT_MAX);
        grant_f_o = arb_en_i && f_req_i && (!p_req_i || starved);
        grant_p_o = arb_en_i && p_req_i && !grant_f_o;
    end

    always_comb begin
        scnt_d = scnt_q;
        if (!f_req_i || f_done_i) begin
            scnt_d = '0;
        end else if (p_done_i && !starved) begin
            scnt_d = scnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scnt_q <= '0;
        end else begin
            scnt_q <= scnt_d;
        end
    end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Single-port data memory controller: shares the memory between the pipeline
// and the fill/debug port, sequencing hits and fixed-latency misses.
//
// state   | meaning
// IDLE    | arbitrating; a granted hit completes in this cycle
// MISS    | owner holds the memory; completes when cnt reaches 0
module dmem_port_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int MISS_LATENCY = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic p_req,
    input  logic f_req,
    input  logic mem_hit,
    output logic mem_address_sel,
    output logic p_stall,
    output logic f_ack,
    output logic busy
);

    localparam int CW = $clog2(MISS_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MISS_LATENCY - 1);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic grant_p, grant_f;
    logic p_done, f_done;
    logic sel_c, p_stall_c;

    dmem_port_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk_i     (clk),
        .rst_i     (reset),
        .arb_en_i  (state_q == ST_IDLE),
        .p_req_i   (p_req),
        .f_req_i   (f_req),
        .p_done_i  (p_done),
        .f_done_i  (f_done),
        .grant_p_o (grant_p),
        .grant_f_o (grant_f)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        sel_c     = 1'b0;
        p_stall_c = p_req;
        p_done    = 1'b0;
        f_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sel_c = grant_f;
                if (grant_p || grant_f) begin
                    if (mem_hit) begin
                        if (grant_p) begin
                            p_stall_c = 1'b0;
                            p_done    = 1'b1;
                        end else begin
                            f_done = 1'b1;
                        end
                    end else begin
                        owner_d = grant_f ? OWN_F : OWN_P;
                        cnt_d   = CNT_LOAD;
                        state_d = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                // mem_hit deliberately plays no part here.
                sel_c = (owner_q == OWN_F);
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_P) begin
                        p_stall_c = 1'b0;
                        p_done    = 1'b1;
                    end else begin
                        f_done = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_P;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low for as long as reset is held, not just after an edge.
    assign mem_address_sel = sel_c & ~reset;
    assign p_stall         = p_stall_c & ~reset;
    assign f_ack           = f_done & ~reset;
    assign busy            = (state_q == ST_MISS) & ~reset;

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Directed bench for dmem_port_ctrl (MISS_LATENCY=4, STARVE_LIMIT=3) plus a
// MISS_LATENCY=1 instance for the single-cycle miss case.
module tb_dmem_port_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic p_req, f_req, mem_hit;
    logic sel, p_stall, f_ack, busy;
    logic sel1, p_stall1, f_ack1, busy1;

    int n_pass  = 0;
    int n_total = 0;
    int cyc;

    always #5 clk = ~clk;

    dmem_port_ctrl #(.MISS_LATENCY(4), .STARVE_LIMIT(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .p_req           (p_req),
        .f_req           (f_req),
        .mem_hit         (mem_hit),
        .mem_address_sel (sel),
        .p_stall         (p_stall),
        .f_ack           (f_ack),
        .busy            (busy)
    );

    dmem_port_ctrl #(.MISS_LATENCY(1), .STARVE_LIMIT(1)) dut1 (
        .clk             (clk),
        .reset           (reset),
        .p_req           (p_req),
        .f_req           (f_req),
        .mem_hit         (mem_hit),
        .mem_address_sel (sel1),
        .p_stall         (p_stall1),
        .f_ack           (f_ack1),
        .busy            (busy1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // sel, p_stall, f_ack, busy of the main instance in one go
    task automatic chk4(input string tag, input logic e_sel, input logic e_stall,
                        input logic e_ack, input logic e_busy);
        chk({tag, ".sel"},     int'(sel),     int'(e_sel));
        chk({tag, ".p_stall"}, int'(p_stall), int'(e_stall));
        chk({tag, ".f_ack"},   int'(f_ack),   int'(e_ack));
        chk({tag, ".busy"},    int'(busy),    int'(e_busy));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic f, input logic h);
        p_req   = p;
        f_req   = f;
        mem_hit = h;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        p_req = 1'b0; f_req = 1'b0; mem_hit = 1'b0;
        tick();
        chk4("reset", 0, 0, 0, 0);
        reset = 1'b0;
        tick();

        // Pipeline hit
        drive(1, 0, 1);
        chk4("p_hit", 0, 0, 0, 0);
        tick();
        chk4("p_hit_again", 0, 0, 0, 0);

        // Pipeline miss: stall cycles 0-3, busy 1-4, done at 4
        drive(1, 0, 0);
        chk4("p_miss.c0", 0, 1, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            drive(1, 0, 1);
            chk4($sformatf("p_miss.c%0d", c), 0, 1, 0, 1);
        end
        tick();
        chk4("p_miss.c4", 0, 0, 0, 1);
        tick();
        drive(0, 0, 1);
        chk4("p_miss.c5", 0, 0, 0, 0);
        tick();

        // Contention: P, P, P, F, P
        drive(1, 1, 1);
        for (int c = 0; c <= 2; c++) begin
            chk4($sformatf("cont.c%0d", c), 0, 0, 0, 0);
            tick();
        end
        chk4("cont.c3", 1, 1, 1, 0);
        tick();
        chk4("cont.c4", 0, 0, 0, 0);
        tick();
        drive(0, 0, 0);
        tick();

        // F miss with the pipeline arriving one cycle later
        drive(0, 1, 0);
        chk4("f_miss.c0", 1, 0, 0, 0);
        tick();
        drive(1, 1, 0);
        for (int c = 1; c <= 3; c++) begin
            chk4($sformatf("f_miss.c%0d", c), 1, 1, 0, 1);
            tick();
        end
        chk4("f_miss.c4", 1, 1, 1, 1);
        tick();
        drive(1, 0, 1);
        chk4("f_miss.c5", 0, 0, 0, 0);
        tick();

        // F only hit
        drive(0, 1, 1);
        chk4("f_only", 1, 0, 1, 0);
        tick();
        drive(0, 0, 0);
        tick();
        tick();

        // MISS_LATENCY=1 instance, and p_req dropped mid-MISS on the main one
        drive(1, 0, 0);
        chk("ml1.c0.p_stall", int'(p_stall1), 1);
        chk("ml1.c0.busy",    int'(busy1),    0);
        chk4("pdrop.c0", 0, 1, 0, 0);
        tick();
        chk("ml1.c1.p_stall", int'(p_stall1), 0);
        chk("ml1.c1.busy",    int'(busy1),    1);
        chk4("pdrop.c1", 0, 1, 0, 1);
        tick();
        drive(0, 0, 0);
        chk("ml1.c2.busy", int'(busy1), 0);
        chk4("pdrop.c2", 0, 0, 0, 1);
        cyc = 2;
        while (busy && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("pdrop.idle_cycle", cyc, 5);
        chk("pdrop.f_ack", int'(f_ack), 0);
        tick();

        // Reset while an F miss is at cnt=1
        drive(0, 1, 0);
        chk4("rst_miss.c0", 1, 0, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            tick();
        end
        chk4("rst_miss.c3", 1, 0, 0, 1);
        reset = 1'b1;
        #1;
        chk4("rst_miss.async", 0, 0, 0, 0);
        drive(0, 0, 0);
        tick();
        reset = 1'b0;
        #1;
        chk4("rst_miss.release", 0, 0, 0, 0);
        tick();
        chk("rst_miss.no_ack", int'(f_ack), 0);
        drive(1, 0, 1);
        chk4("rst_miss.p_hit", 0, 0, 0, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
